// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: state codes, opcodes
// and the datapath select encodings.
package multicycle_control_fsm_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle FSM (master) and the datapath (slave).
interface multicycle_control_fsm_if;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       illegal_op;
  logic       instr_done;

  modport master (
    input  Opcode, mem_ready,
    output IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, PCWrite, PCWriteCond,
           illegal_op, instr_done
  );

  modport slave (
    output Opcode, mem_ready,
    input  IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, PCWrite, PCWriteCond,
           illegal_op, instr_done
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle MIPS datapath: steps each instruction
// through fetch/decode/execute/memory/writeback and drives every datapath control.
//
// state    | meaning
// FETCH    | read instruction at PC, commit IR load and PC+4 on mem_ready
// DECODE   | opcode decode, branch target precompute, opcode latched
// MEM_ADDR | effective address = A + sign-ext imm
// MEM_RD   | load data read at ALUOut, held until mem_ready
// MEM_WB   | write MDR to rt
// MEM_WR   | store B at ALUOut, held until mem_ready
// EXEC_R   | R-type ALU operation
// EXEC_I   | addi ALU operation
// ALU_WB   | write ALUOut to rd (R-type) or rt (addi)
// BRANCH   | beq compare, conditional PC load
// JUMP     | PC load from jump target
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int STATE_W     = 4,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  multicycle_control_fsm_if.master  bus,
  output logic [STATE_W-1:0]        state
);

  state_e     state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  logic       ready;

  logic       mem_read, mem_write, ir_write, reg_write, pc_write, pc_write_cond;
  logic       illegal, done;

  assign ready = bus.mem_ready | ~MEM_WAIT_EN;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  always_comb begin
    state_d  = S_FETCH;
    opcode_d = opcode_q;
    case (state_q)
      S_FETCH:    state_d = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        opcode_d = bus.Opcode;
        case (bus.Opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   state_d = ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R,
      S_EXEC_I:   state_d = S_ALU_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    bus.IorD      = 1'b0;
    bus.RegDst    = 1'b0;
    bus.MemtoReg  = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = SRCB_REG;
    bus.ALUOp     = ALUOP_ADD;
    bus.PCSource  = PCSRC_ALU;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    illegal       = 1'b0;
    done          = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read    = 1'b1;
        // IR load and PC+4 only in the ready cycle so PC advances exactly once
        ir_write    = ready;
        pc_write    = ready;
        bus.ALUSrcB = SRCB_FOUR;
      end
      S_DECODE: begin
        bus.ALUSrcB = SRCB_IMM_SH2;
        illegal     = ~op_is_legal(bus.Opcode);
      end
      S_MEM_ADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        bus.IorD = 1'b1;
      end
      S_MEM_WB: begin
        bus.MemtoReg = 1'b1;
        reg_write    = 1'b1;
        done         = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        bus.IorD  = 1'b1;
        done      = ready;
      end
      S_EXEC_R: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_ALU_WB: begin
        bus.RegDst = (opcode_q == OP_RTYPE);
        reg_write  = 1'b1;
        done       = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUOp     = ALUOP_SUB;
        bus.PCSource  = PCSRC_ALUOUT;
        pc_write_cond = 1'b1;
        done          = 1'b1;
      end
      S_JUMP: begin
        bus.PCSource = PCSRC_JUMP;
        pc_write     = 1'b1;
        done         = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes and pulses are gated so nothing commits while reset is held
  assign bus.MemRead     = mem_read      & ~reset;
  assign bus.MemWrite    = mem_write     & ~reset;
  assign bus.IRWrite     = ir_write      & ~reset;
  assign bus.RegWrite    = reg_write     & ~reset;
  assign bus.PCWrite     = pc_write      & ~reset;
  assign bus.PCWriteCond = pc_write_cond & ~reset;
  assign bus.illegal_op  = illegal       & ~reset;
  assign bus.instr_done  = done          & ~reset;

  assign state = STATE_W'(state_q);

endmodule
